// File: rtl/mbist_march_fsm.sv
// March C- sequencer: steps six March elements over the address window and drives
// the address generator, read/write ops with data polarity, and a sticky error flag.
module mbist_march_fsm #(
  parameter int BIST_CMP_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bist_en,
  input  logic       last_addr,
  input  logic       cmp_err,
  output logic       bist_load,
  output logic       run,
  output logic       updown,
  output logic       op_we,
  output logic       op_re,
  output logic       op_data,
  output logic [2:0] elem,
  output logic       bist_done,
  output logic       bist_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  localparam logic [1:0] FLUSH_LAST = 2'(BIST_CMP_LAT - 1);

  state_t                  state;
  logic [2:0]              elem_q;
  logic                    op_idx;
  logic [1:0]              flush_cnt;
  logic [BIST_CMP_LAT-1:0] rd_vld_p;

  logic last_op;
  logic elem_end;
  logic same_dir_next;
  logic err_hit;

  always_comb begin
    last_op       = (elem_q == 3'd0) || (elem_q == 3'd5) || op_idx;
    elem_end      = (state == S_RUN) && last_op && last_addr;
    same_dir_next = (elem_q != 3'd2) && (elem_q != 3'd5);
    err_hit       = cmp_err && rd_vld_p[BIST_CMP_LAT-1];
  end

  // Output decode: everything but run is a function of registered state only
  always_comb begin
    bist_load = (state == S_LOAD);
    bist_done = (state == S_DONE);
    updown    = 1'b1;
    op_we     = 1'b0;
    op_re     = 1'b0;
    op_data   = 1'b0;
    run       = 1'b0;
    if ((state == S_RUN) || (state == S_FLUSH) || (state == S_DONE))
      updown = (elem_q < 3'd3);
    if (state == S_RUN) begin
      case (elem_q)
        3'd0: begin
          op_we   = 1'b1;
          op_data = 1'b0;
        end
        3'd5: begin
          op_re   = 1'b1;
          op_data = 1'b0;
        end
        default: begin
          // M1/M3 read 0 then write 1; M2/M4 read 1 then write 0
          op_re   = ~op_idx;
          op_we   = op_idx;
          op_data = op_idx ^ ((elem_q == 3'd2) || (elem_q == 3'd4));
        end
      endcase
      // Element end holds the address only when the direction flips or the test ends
      if (last_op)
        run = last_addr ? same_dir_next : 1'b1;
    end
  end

  assign elem = elem_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      elem_q     <= 3'd0;
      op_idx     <= 1'b0;
      flush_cnt  <= 2'd0;
      rd_vld_p   <= '0;
      bist_error <= 1'b0;
    end else begin
      // Read-valid pipeline stage boundary: aligns each read with its compare result
      rd_vld_p[0] <= op_re;
      for (int i = 1; i < BIST_CMP_LAT; i++)
        rd_vld_p[i] <= rd_vld_p[i-1];
      if (err_hit)
        bist_error <= 1'b1;

      case (state)
        S_IDLE: begin
          if (bist_en) begin
            state      <= S_LOAD;
            elem_q     <= 3'd0;
            op_idx     <= 1'b0;
            bist_error <= 1'b0;
          end
        end
        S_LOAD: state <= S_RUN;
        S_RUN: begin
          if (elem_end) begin
            op_idx <= 1'b0;
            if (elem_q == 3'd5) begin
              state     <= S_FLUSH;
              flush_cnt <= 2'd0;
            end else begin
              elem_q <= elem_q + 3'd1;
            end
          end else if (last_op) begin
            op_idx <= 1'b0;
          end else begin
            op_idx <= 1'b1;
          end
        end
        S_FLUSH: begin
          if (flush_cnt == FLUSH_LAST)
            state <= S_DONE;
          else
            flush_cnt <= flush_cnt + 2'd1;
        end
        S_DONE: begin
          if (!bist_en)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (!bist_en && ((state == S_LOAD) || (state == S_RUN) || (state == S_FLUSH))) begin
        state    <= S_IDLE;
        rd_vld_p <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mbist_march_fsm.sv
// Bench for mbist_march_fsm: behavioural address generator, op scoreboard and
// directed runs covering completion timing, error capture, abort and reset.
module tb_mbist_march_fsm;

  logic       clk = 1'b0;
  logic       rst_n, bist_en, last_addr, cmp_err;
  logic       bist_load, run, updown, op_we, op_re, op_data, bist_done, bist_error;
  logic [2:0] elem;
  logic [7:0] addr = 8'd0;
  logic [7:0] win_start, win_end;

  int checks = 0;
  int errors = 0;
  int n_wr = 0;
  int n_rd = 0;
  bit sb_on = 1'b0;
  int dc, fe;

  typedef struct packed {
    logic       we;
    logic       re;
    logic       data;
    logic       run;
    logic       up;
    logic [2:0] el;
    logic [7:0] ad;
  } op_t;

  op_t exp_q[$];

  always #5 clk = ~clk;

  mbist_march_fsm #(.BIST_CMP_LAT(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bist_en    (bist_en),
    .last_addr  (last_addr),
    .cmp_err    (cmp_err),
    .bist_load  (bist_load),
    .run        (run),
    .updown     (updown),
    .op_we      (op_we),
    .op_re      (op_re),
    .op_data    (op_data),
    .elem       (elem),
    .bist_done  (bist_done),
    .bist_error (bist_error)
  );

  // Address generator stand-in: load to start, wrap at the window edge
  always @(posedge clk) begin
    if (bist_load)
      addr <= win_start;
    else if (run) begin
      if (updown)
        addr <= (addr == win_end) ? win_start : addr + 8'd1;
      else
        addr <= (addr == win_start) ? win_end : addr - 8'd1;
    end
  end
  assign last_addr = updown ? (addr == win_end) : (addr == win_start);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every op the DUT presents is matched against the queue
  op_t mon_e, mon_a;
  always @(negedge clk) begin
    if (sb_on && (op_we || op_re)) begin
      if (op_we) n_wr++;
      if (op_re) n_rd++;
      if (exp_q.size() == 0)
        chk("op_unexpected", exp_q.size(), 1);
      else begin
        mon_e = exp_q.pop_front();
        mon_a = {op_we, op_re, op_data, run, updown, elem, addr};
        chk("op", mon_a, mon_e);
      end
    end
  end

  // Hand-listed March C- table: M0 w0 | M1 r0 w1 | M2 r1 w0 | M3 r0 w1 | M4 r1 w0 | M5 r0
  task automatic push_run(input int s, input int e);
    int  nops[6];
    bit  we0[6];
    bit  d0[6];
    bit  d1[6];
    int  n;
    op_t o;
    bit  up, la, lo;
    nops = '{1, 2, 2, 2, 2, 1};
    we0  = '{1, 0, 0, 0, 0, 0};
    d0   = '{0, 0, 1, 0, 1, 0};
    d1   = '{0, 1, 0, 1, 0, 0};
    n = e - s + 1;
    for (int el = 0; el < 6; el++) begin
      up = (el < 3);
      for (int a = 0; a < n; a++) begin
        la = (a == n - 1);
        for (int k = 0; k < nops[el]; k++) begin
          lo     = (k == nops[el] - 1);
          o.we   = (k == 0) ? we0[el] : 1'b1;
          o.re   = ~o.we;
          o.data = (k == 0) ? d0[el] : d1[el];
          o.run  = lo && (!la || (el != 2 && el != 5));
          o.up   = up;
          o.el   = 3'(el);
          o.ad   = up ? 8'(s + a) : 8'(e - a);
          exp_q.push_back(o);
        end
      end
    end
  endtask

  // mode 1: cmp_err after the M3 read at address 1; mode 2: cmp_err after every write
  task automatic run_test(input int mode, input int abort_at, input int rst_at,
                          output int done_cyc, output int first_err);
    bit inj;
    done_cyc  = 0;
    first_err = 0;
    cmp_err   = 1'b0;
    bist_en   = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("load_bist_load", bist_load, 1);
        chk("load_error_clr", bist_error, 0);
        chk("load_elem", elem, 0);
        chk("load_updown", updown, 1);
        chk("load_run", run, 0);
      end
      if (bist_error && first_err == 0) first_err = c;
      if (abort_at != 0 && c == abort_at) chk("abort_in_m2", elem, 2);
      if (abort_at != 0 && c == abort_at + 1) begin
        chk("abort_ops", {op_we, op_re, run, bist_load, bist_done}, 5'b0);
        cmp_err = 1'b0;
        return;
      end
      if (rst_at != 0 && c == rst_at) chk("flush_ops", {op_we, op_re, bist_done}, 3'b0);
      if (rst_at != 0 && c == rst_at + 1) begin
        chk("rst_flush_outs", {bist_load, run, updown, op_we, op_re, op_data, bist_done, bist_error},
            8'b0010_0000);
        chk("rst_flush_elem", elem, 0);
        cmp_err = 1'b0;
        return;
      end
      if (bist_done) begin
        done_cyc = c;
        break;
      end
      inj = (mode == 1 && op_re && elem == 3'd3 && addr == 8'd1) || (mode == 2 && op_we);
      @(posedge clk);
      #1;
      cmp_err = inj;
      if (abort_at == c + 1) bist_en = 1'b0;
      if (rst_at == c + 1) rst_n = 1'b0;
    end
    cmp_err = 1'b0;
  endtask

  task automatic finish_run(input logic exp_err);
    bist_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("idle_done_low", bist_done, 0);
    chk("idle_error", bist_error, exp_err);
  endtask

  initial begin
    rst_n = 1'b0; bist_en = 1'b0; cmp_err = 1'b0;
    win_start = 8'd0; win_end = 8'd3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_bist_load", bist_load, 0);
    chk("rst_run", run, 0);
    chk("rst_updown", updown, 1);
    chk("rst_op_we", op_we, 0);
    chk("rst_op_re", op_re, 0);
    chk("rst_op_data", op_data, 0);
    chk("rst_elem", elem, 0);
    chk("rst_done", bist_done, 0);
    chk("rst_error", bist_error, 0);
    rst_n = 1'b1;

    // Full N=4 run, no errors
    push_run(0, 3); sb_on = 1'b1; n_wr = 0; n_rd = 0;
    run_test(0, 0, 0, dc, fe);
    chk("n4_done_cycle", dc, 43);
    chk("n4_error", bist_error, 0);
    chk("n4_writes", n_wr, 20);
    chk("n4_reads", n_rd, 20);
    chk("n4_queue_empty", exp_q.size(), 0);
    finish_run(1'b0);

    // Compare error after the M3 read at address 1
    push_run(0, 3); n_wr = 0; n_rd = 0;
    run_test(1, 0, 0, dc, fe);
    chk("err_first_cycle", fe, 28);
    chk("err_done_cycle", dc, 43);
    chk("err_in_done", bist_error, 1);
    finish_run(1'b1);

    // Compare errors after writes only are ignored; LOAD clears the old error
    push_run(0, 3);
    run_test(2, 0, 0, dc, fe);
    chk("wr_err_first", fe, 0);
    chk("wr_err_done", dc, 43);
    chk("wr_err_flag", bist_error, 0);
    finish_run(1'b0);
    chk("q_empty_b", exp_q.size(), 0);

    // Abort mid-M2, then a full restart
    sb_on = 1'b0;
    run_test(0, 17, 0, dc, fe);
    sb_on = 1'b1; push_run(0, 3); n_wr = 0; n_rd = 0;
    run_test(0, 0, 0, dc, fe);
    chk("restart_done_cycle", dc, 43);
    chk("restart_ops", n_wr + n_rd, 40);
    finish_run(1'b0);

    // N=1 window: reset in FLUSH, then a clean run
    win_start = 8'd2; win_end = 8'd2;
    sb_on = 1'b0;
    run_test(0, 0, 12, dc, fe);
    bist_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_hold_no_done", bist_done, 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_no_done", bist_done, 0);
    sb_on = 1'b1; push_run(2, 2); n_wr = 0; n_rd = 0;
    run_test(0, 0, 0, dc, fe);
    chk("n1_done_cycle", dc, 13);
    chk("n1_writes", n_wr, 5);
    chk("n1_reads", n_rd, 5);
    chk("n1_queue_empty", exp_q.size(), 0);
    finish_run(1'b0);
    sb_on = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
